// File: rtl/act_mem_ext_streamer_pkg.sv
// Shared types and constants for the activation-memory external streamer.
// The ACT_STREAMER_PERF_CNT_EN build macro enables the stall counter in the top.
package act_mem_ext_streamer_pkg;

    localparam int ACT_STREAM_N      = 16;
    localparam int ACT_STREAM_ACT_W  = 8;
    localparam int ACT_STREAM_BEAT_W = 32;
    localparam int ACT_STREAM_BPW    = ACT_STREAM_N * ACT_STREAM_ACT_W / ACT_STREAM_BEAT_W;

    typedef logic signed [ACT_STREAM_ACT_W-1:0] act_elem_t;
    typedef act_elem_t [ACT_STREAM_N-1:0]       act_word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STORE,
        ST_DONE
    } streamer_state_e;

    function automatic int beatsPerWord(input int nElem, input int elemW, input int beatW);
        return nElem * elemW / beatW;
    endfunction

endpackage

// File: rtl/act_stream_word_fifo.sv
// Two-entry word FIFO with occupancy output, buffering memory reads on the store path.
// The controller never pushes when full nor pops when empty.
module act_stream_word_fifo #(
    parameter int WORD_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [WORD_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [WORD_W-1:0] head_o,
    output logic [1:0]        occ_o
);

    logic [WORD_W-1:0] mem_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        occ_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push_i) wr_ptr_q <= ~wr_ptr_q;
            if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
            occ_q <= occ_q + 2'(push_i) - 2'(pop_i);
        end
    end

    // Storage is not reset: an entry is only observed after it has been pushed.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o = mem_q[rd_ptr_q];
    assign occ_o  = occ_q;

endmodule

// File: rtl/act_mem_ext_streamer.sv
// Moves whole activation words between the external memory port and a beat stream.
// Define ACT_STREAMER_PERF_CNT_EN to build the saturating stall counter.
module act_mem_ext_streamer
    import act_mem_ext_streamer_pkg::*;
#(
    parameter int N_DIM_ARRAY    = ACT_STREAM_N,
    parameter int ACT_DATA_WIDTH = ACT_STREAM_ACT_W,
    parameter int ADDR_W         = 16,
    parameter int BEAT_W         = ACT_STREAM_BEAT_W
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                cmd_valid,
    output logic                                cmd_ready,
    input  logic                                cmd_dir,
    input  logic [ADDR_W-1:0]                   cmd_addr,
    input  logic [ADDR_W-1:0]                   cmd_len,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [BEAT_W-1:0]                   in_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [BEAT_W-1:0]                   out_data,
    output logic                                out_last,
    output logic                                wr_en_ext,
    output logic [ADDR_W-1:0]                   wr_addr_ext,
    output logic [N_DIM_ARRAY*ACT_DATA_WIDTH-1:0] wr_data_ext,
    output logic                                rd_en_ext,
    output logic [ADDR_W-1:0]                   rd_addr_ext,
    input  logic [N_DIM_ARRAY*ACT_DATA_WIDTH-1:0] rd_data_ext,
    output logic                                busy,
    output logic                                done,
    output logic [31:0]                         stall_cnt
);

    localparam int WORD_W = N_DIM_ARRAY * ACT_DATA_WIDTH;
    localparam int BPW    = beatsPerWord(N_DIM_ARRAY, ACT_DATA_WIDTH, BEAT_W);
    localparam int CNT_W  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BPW - 1);
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(N_DIM_ARRAY);
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(N_DIM_ARRAY - 1);

    streamer_state_e   state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] left_q;
    logic [CNT_W-1:0]  beat_cnt_q;
    logic [WORD_W-1:0] asm_q;
    logic              cmd_ready_q, busy_q, done_q;
    logic              wr_en_q, rd_en_q, rd_vld_q;
    logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;
    logic [WORD_W-1:0] wr_data_q;

    logic              in_hs, out_hs, last_beat, rd_issue, fifo_pop;
    logic [WORD_W-1:0] asm_next, fifo_head;
    logic [1:0]        fifo_occ;
    logic [2:0]        occ_after;

    // left_q counts words still to assemble (load) or still to read (store);
    // len_q counts words still to write (load) or still to emit (store).
    assign in_ready  = (state_q == ST_LOAD) && (left_q != '0);
    assign in_hs     = in_valid && in_ready;
    assign out_valid = (state_q == ST_STORE) && (fifo_occ != 2'd0);
    assign out_hs    = out_valid && out_ready;
    assign last_beat = (beat_cnt_q == LAST_BEAT);
    assign out_last  = out_valid && last_beat && (len_q == ADDR_W'(1));
    assign out_data  = out_valid ? BEAT_W'(fifo_head >> (32'(beat_cnt_q) * 32'(BEAT_W))) : '0;
    assign fifo_pop  = out_hs && last_beat;
    assign asm_next  = WORD_W'({in_data, asm_q} >> BEAT_W);

    // Words resident or in flight after this edge, before any new read is issued.
    assign occ_after = 3'(fifo_occ) + 3'(rd_vld_q) + 3'(rd_en_q) - 3'(fifo_pop);
    assign rd_issue  = (state_q == ST_STORE) && (left_q != '0) && (occ_after < 3'd2);

    act_stream_word_fifo #(.WORD_W(WORD_W)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (rd_vld_q),
        .push_data_i (rd_data_ext),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .occ_o       (fifo_occ)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            left_q      <= '0;
            beat_cnt_q  <= '0;
            asm_q       <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_vld_q    <= 1'b0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            wr_en_q  <= 1'b0;
            rd_en_q  <= 1'b0;
            done_q   <= 1'b0;
            rd_vld_q <= rd_en_q;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        addr_q      <= cmd_addr & ADDR_MASK;
                        len_q       <= cmd_len;
                        left_q      <= cmd_len;
                        beat_cnt_q  <= '0;
                        if (cmd_len == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else if (cmd_dir) begin
                            state_q   <= ST_STORE;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= cmd_addr & ADDR_MASK;
                            addr_q    <= (cmd_addr & ADDR_MASK) + STEP;
                            left_q    <= cmd_len - ADDR_W'(1);
                        end else begin
                            state_q <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (in_hs) begin
                        asm_q      <= asm_next;
                        beat_cnt_q <= last_beat ? '0 : beat_cnt_q + CNT_W'(1);
                        if (last_beat) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= addr_q;
                            wr_data_q <= asm_next;
                            addr_q    <= addr_q + STEP;
                            left_q    <= left_q - ADDR_W'(1);
                        end
                    end
                    if (wr_en_q) begin
                        len_q <= len_q - ADDR_W'(1);
                        if (len_q == ADDR_W'(1)) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_STORE: begin
                    if (rd_issue) begin
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= addr_q;
                        addr_q    <= addr_q + STEP;
                        left_q    <= left_q - ADDR_W'(1);
                    end
                    if (out_hs) begin
                        beat_cnt_q <= last_beat ? '0 : beat_cnt_q + CNT_W'(1);
                        if (last_beat) begin
                            len_q <= len_q - ADDR_W'(1);
                            if (len_q == ADDR_W'(1)) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign wr_en_ext   = wr_en_q;
    assign wr_addr_ext = wr_addr_q;
    assign wr_data_ext = wr_data_q;
    assign rd_en_ext   = rd_en_q;
    assign rd_addr_ext = rd_addr_q;

`ifdef ACT_STREAMER_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic        stall;

    // A load cycle only counts while a beat is actually wanted, so the write-back cycle is not a stall.
    assign stall = ((state_q == ST_LOAD) && in_ready && !in_valid) ||
                   ((state_q == ST_STORE) && !out_hs);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if ((state_q == ST_IDLE) && cmd_valid && cmd_ready_q) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_act_mem_ext_streamer.sv
// Scoreboard bench for act_mem_ext_streamer: stimulus pushes expected writes, reads and beats,
// a negedge monitor pops and compares them; stall_cnt expectation follows ACT_STREAMER_PERF_CNT_EN.
module tb_act_mem_ext_streamer;

    localparam int ADDR_W = 16;
    localparam int BEAT_W = 32;
    localparam int WORD_W = 128;
    localparam int BPW    = 4;
`ifdef ACT_STREAMER_PERF_CNT_EN
    localparam int EXP_STALL = 5;
`else
    localparam int EXP_STALL = 0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              cmd_valid = 1'b0, cmd_dir = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0, cmd_len = '0;
    logic              cmd_ready;
    logic              in_valid = 1'b0, in_ready;
    logic [BEAT_W-1:0] in_data = '0;
    logic              out_valid, out_ready = 1'b1, out_last;
    logic [BEAT_W-1:0] out_data;
    logic              wr_en_ext, rd_en_ext, busy, done;
    logic [ADDR_W-1:0] wr_addr_ext, rd_addr_ext;
    logic [WORD_W-1:0] wr_data_ext, rd_data_ext = '0;
    logic [31:0]       stall_cnt;

    act_mem_ext_streamer dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .wr_en_ext(wr_en_ext), .wr_addr_ext(wr_addr_ext), .wr_data_ext(wr_data_ext),
        .rd_en_ext(rd_en_ext), .rd_addr_ext(rd_addr_ext), .rd_data_ext(rd_data_ext),
        .busy(busy), .done(done), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int unsigned cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    logic [ADDR_W+WORD_W-1:0] expWr[$];
    logic [ADDR_W-1:0]        expRd[$];
    logic [BEAT_W:0]          expOut[$];
    logic [BEAT_W-1:0]        beatBuf[$];
    logic [WORD_W-1:0]        tbMem [4096];

    int nCompared = 0, nMismatch = 0;
    int wrCount, rdIssued, outBeats;
    int lastWrCycle, firstRdCycle, firstOutCycle, lastOutCycle;
    bit toggleReady = 1'b0;

    task automatic checkOutput(input string name, input logic [159:0] actual, input logic [159:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatch++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [ADDR_W-1:0] wordAddr(input logic [ADDR_W-1:0] base, input int w);
        return (base & 16'hFFF0) + 16'(16 * w);
    endfunction

    // Reference: word w lives at base+16w; beat b of a word is bits [32b+31:32b].
    task automatic pushLoadModel(input logic [ADDR_W-1:0] addr, input int len);
        logic [WORD_W-1:0] word;
        for (int w = 0; w < len; w++) begin
            for (int b = 0; b < BPW; b++) word[32*b +: 32] = beatBuf[w*BPW + b];
            expWr.push_back({wordAddr(addr, w), word});
        end
    endtask

    task automatic pushStoreModel(input logic [ADDR_W-1:0] addr, input int len);
        logic [ADDR_W-1:0] a;
        logic [WORD_W-1:0] word;
        for (int w = 0; w < len; w++) begin
            a = wordAddr(addr, w);
            word = tbMem[a[15:4]];
            expRd.push_back(a);
            for (int b = 0; b < BPW; b++)
                expOut.push_back({(w == len - 1) && (b == BPW - 1), word[32*b +: 32]});
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a write, read or beat.
    initial forever begin
        logic [ADDR_W+WORD_W-1:0] ew;
        logic [BEAT_W:0] eo;
        @(negedge clk);
        if (wr_en_ext) begin
            wrCount++;
            lastWrCycle = cycle;
            checkOutput("wr_expected", 160'(expWr.size() != 0), 160'(1));
            if (expWr.size() != 0) begin
                ew = expWr.pop_front();
                checkOutput("wr_addr", 160'(wr_addr_ext), 160'(ew[WORD_W +: ADDR_W]));
                checkOutput("wr_data", 160'(wr_data_ext), 160'(ew[WORD_W-1:0]));
            end
        end
        if (rd_en_ext) begin
            rdIssued++;
            if (rdIssued == 1) firstRdCycle = cycle;
            checkOutput("rd_expected", 160'(expRd.size() != 0), 160'(1));
            if (expRd.size() != 0) checkOutput("rd_addr", 160'(rd_addr_ext), 160'(expRd.pop_front()));
            checkOutput("rd_outstanding_le2", 160'((rdIssued - outBeats / BPW) <= 2), 160'(1));
        end
        if (out_valid && out_ready) begin
            outBeats++;
            if (outBeats == 1) firstOutCycle = cycle;
            lastOutCycle = cycle;
            checkOutput("out_expected", 160'(expOut.size() != 0), 160'(1));
            if (expOut.size() != 0) begin
                eo = expOut.pop_front();
                checkOutput("out_data", 160'(out_data), 160'(eo[BEAT_W-1:0]));
                checkOutput("out_last", 160'(out_last), 160'(eo[BEAT_W]));
            end
        end
    end

    // Memory model: read data appears the cycle after the strobe.
    initial forever begin
        logic req;
        logic [ADDR_W-1:0] ra;
        @(negedge clk);
        req = rd_en_ext;
        ra  = rd_addr_ext;
        @(posedge clk);
        #1;
        if (req) rd_data_ext = tbMem[ra[15:4]];
    end

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = toggleReady ? ~out_ready : 1'b1;
    end

    task automatic resetCounters();
        wrCount = 0; rdIssued = 0; outBeats = 0;
        lastWrCycle = -1; firstRdCycle = -1; firstOutCycle = -1; lastOutCycle = -1;
    endtask

    task automatic applyStimulus(input logic dir, input logic [ADDR_W-1:0] addr,
                                 input logic [ADDR_W-1:0] len, output int acc);
        bit got = 0;
        acc = -1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1; cmd_dir = dir; cmd_addr = addr; cmd_len = len;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (cmd_ready) begin got = 1; acc = cycle; end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        checkOutput("cmd_accept", 160'(got), 160'(1));
    endtask

    task automatic driveBeats(input int nBeats, input int initGap, input bit randGaps);
        bit hs;
        in_valid = 1'b0;
        repeat (initGap) begin @(posedge clk); #1; end
        for (int i = 0; i < nBeats; i++) begin
            if (randGaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = beatBuf[i];
            hs = 0;
            for (int k = 0; k < 50 && !hs; k++) begin
                @(negedge clk);
                hs = in_ready;
                @(posedge clk); #1;
            end
            if (!hs) checkOutput("in_handshake", 160'(hs), 160'(1));
        end
        in_valid = 1'b0;
    endtask

    task automatic waitDone(input int budget, output int dc);
        dc = -1;
        for (int k = 0; k < budget && dc < 0; k++) begin
            @(negedge clk);
            if (done) dc = cycle;
        end
        checkOutput("done_seen", 160'(dc >= 0), 160'(1));
    endtask

    task automatic runLoad(input logic [ADDR_W-1:0] addr, input int len, input int initGap,
                           input bit randGaps, input bit fixedData);
        int acc, dc;
        beatBuf.delete();
        for (int i = 0; i < len * BPW; i++)
            beatBuf.push_back(fixedData ? {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)} : $urandom);
        pushLoadModel(addr, len);
        resetCounters();
        applyStimulus(1'b0, addr, 16'(len), acc);
        checkOutput("load_busy", 160'(busy), 160'(1));
        driveBeats(len * BPW, initGap, randGaps);
        waitDone(100, dc);
        checkOutput("load_done_timing", 160'(dc), 160'(lastWrCycle + 1));
        checkOutput("load_wr_count", 160'(wrCount), 160'(len));
    endtask

    task automatic runStore(input logic [ADDR_W-1:0] addr, input int len, input bit toggle);
        int acc, dc;
        pushStoreModel(addr, len);
        resetCounters();
        toggleReady = toggle;
        applyStimulus(1'b1, addr, 16'(len), acc);
        checkOutput("store_busy", 160'(busy), 160'(1));
        waitDone(300, dc);
        toggleReady = 1'b0;
        checkOutput("store_first_rd", 160'(firstRdCycle), 160'(acc + 1));
        checkOutput("store_beats", 160'(outBeats), 160'(len * BPW));
        checkOutput("store_done_timing", 160'(dc), 160'(lastOutCycle + 1));
        if (!toggle) begin
            checkOutput("store_first_out", 160'(firstOutCycle), 160'(acc + 3));
            checkOutput("store_back_to_back", 160'(lastOutCycle - firstOutCycle), 160'(len * BPW - 1));
        end
    endtask

    task automatic runZero(input logic dir);
        int acc, dc;
        resetCounters();
        applyStimulus(dir, 16'($urandom), 16'd0, acc);
        waitDone(10, dc);
        checkOutput("zero_done_timing", 160'(dc), 160'(acc + 1));
        checkOutput("zero_no_activity", 160'(wrCount + rdIssued + outBeats), 160'(0));
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_cmd_ready"}, 160'(cmd_ready), 160'(1));
        checkOutput({tag, "_ctrl"}, 160'({busy, done, wr_en_ext, rd_en_ext, in_ready, out_valid, out_last}), 160'(0));
        checkOutput({tag, "_buses"}, 160'({out_data, wr_addr_ext, rd_addr_ext, stall_cnt}), 160'(0));
        checkOutput({tag, "_wr_data"}, 160'(wr_data_ext), 160'(0));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) tbMem[i] = {$urandom, $urandom, $urandom, $urandom};
        resetCounters();
        repeat (3) @(posedge clk);
        #1;
        checkResetValues("reset");
        reset = 1'b1;

        runLoad(16'h0000, 2, 0, 1'b0, 1'b1);
        runStore(16'h8000, 3, 1'b0);
        runStore(16'h8040, 2, 1'b1);
        runZero(1'b0);
        runZero(1'b1);
        runStore(16'hFFF0, 2, 1'b0);

        // Abort a load halfway through its first word; nothing may be written.
        beatBuf.delete();
        for (int i = 0; i < BPW; i++) beatBuf.push_back($urandom);
        begin
            int acc;
            resetCounters();
            applyStimulus(1'b0, 16'h0120, 16'd1, acc);
            driveBeats(2, 0, 1'b0);
            reset = 1'b0;
            #1;
            checkResetValues("midreset");
            repeat (3) @(posedge clk);
            #1;
            reset = 1'b1;
            checkOutput("midreset_no_write", 160'(wrCount), 160'(0));
        end
        runLoad(16'h0120, 1, 0, 1'b0, 1'b0);

        runLoad(16'h4000, 1, 5, 1'b0, 1'b0);
        checkOutput("stall_cnt", 160'(stall_cnt), 160'(EXP_STALL));

        for (int t = 0; t < 8; t++) begin
            if ($urandom_range(0, 1) == 1)
                runStore(16'($urandom), int'($urandom_range(1, 3)), bit'($urandom_range(0, 1)));
            else
                runLoad(16'($urandom), int'($urandom_range(1, 3)), 0, 1'b1, 1'b0);
        end

        repeat (3) @(posedge clk);
        checkOutput("wr_queue_drained", 160'(expWr.size()), 160'(0));
        checkOutput("rd_queue_drained", 160'(expRd.size()), 160'(0));
        checkOutput("out_queue_drained", 160'(expOut.size()), 160'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
